mic_playback_dma: RTL and testbench
===================================

# mic_playback_dma

Avalon-MM read-master DMA that streams recorded microphone samples back out of SDRAM. It walks the same per-pair region layout the capture DMA writes: one region per mic pair, with a fixed region stride. It emits samples in sample-interleaved order (pair 0..N-1 for sample 0, then sample 1, …) on a valid/ready stream toward the playback/analysis path. Control comes from the same Avalon-MM slave register block that drives capture.

## Interface
Parameters:
- NUM_MIC_PAIRS, 5, number of regions/channels (1..8)
- REGION_STRIDE, 32'd7680000, byte distance between consecutive pair regions
- FIFO_DEPTH, 8, return-data FIFO entries (power of 2, ≥2)

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high
- AM_ADDR  out  32  read byte address
- AM_BURSTCOUNT  out  3  fixed 3'd1
- AM_BYTEENABLE  out  4  fixed 4'hF
- AM_READ  out  1  read request
- AM_WAITREQUEST  in  1  slave stall
- AM_READDATA  in  32  returned word
- AM_READDATAVALID  in  1  returned word valid
- start  in  1  level; rising into IDLE begins a transfer
- start_address  in  32  base of pair-0 region
- number_samples  in  32  samples per pair
- end_ack  in  1  clears end_latch
- out_data  out  32  sample word
- out_pair  out  3  pair index of out_data
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- end_latch  out  1  sticky "all samples delivered"
- FINISHED  out  1  high in FIN state
- busy  out  1  high outside IDLE/FIN

## Operation
- States: IDLE, SETUP, ISSUE, DRAIN, FIN.
- IDLE: start=1 → SETUP.
- SETUP: latch start_address and number_samples. Clear read counters (req_pair, req_sample) and delivered count. If number_samples==0 → FIN, else → ISSUE.
- ISSUE: AM_ADDR = base + req_pair*REGION_STRIDE + 4*req_sample, 32-bit modulo arithmetic.
  - Assert AM_READ only when credit allows: outstanding + fifo_count < FIFO_DEPTH.
  - Once asserted, AM_READ/AM_ADDR hold stable until AM_WAITREQUEST=0.
  - On accept, increment outstanding and advance req_pair. On wrap to 0, advance req_sample.
  - After the last request (pair N-1, sample number_samples-1) is accepted → DRAIN.
- Return path: each AM_READDATAVALID pushes {pair tag, data} into the FIFO and decrements outstanding. Pair tags are assigned in issue order; the slave returns in order.
- DRAIN: wait until outstanding==0 and FIFO empty with the final word popped → FIN.
- FIN: FINISHED=1, AM_READ=0. start=0 → IDLE. start held high stays in FIN (no restart).
- Output: out_valid = FIFO non-empty. A pop occurs when out_valid & out_ready.
- end_latch: set when the final word pops. end_ack clears it and wins over a same-cycle set.
- AM_READDATAVALID in IDLE/FIN is ignored and does not push.
- RESET mid-transfer: state IDLE, FIFO flushed, counters cleared. Late readdatavalids are ignored by the IDLE rule.

## Timing
- Reset values: AM_READ=0, AM_ADDR=0, out_valid=0, out_pair=0, out_data=0, end_latch=0, FINISHED=0, busy=0, and half_way_latch=0 when the half-way feature is compiled in.
- start→first AM_READ: 2 cycles (IDLE→SETUP→ISSUE).
- Throughput: one read accepted per cycle while credit is available and AM_WAITREQUEST=0.
- readdatavalid → out_valid: 1 cycle (registered FIFO).
- Simultaneous push and pop on a full FIFO is legal; credit accounting prevents overflow.
- out_data/out_pair hold stable while out_valid=1 and out_ready=0.

## Configuration
- MIC_PLAYBACK_DMA_HALF_LATCH_EN defined: adds ports half_way_ack (in, 1) and half_way_latch (out, 1).
  - half_way_latch sets when the delivered sample-frame count (completed pair-N-1 pops) ≥ number_samples/2 (integer divide) and the transfer is busy.
  - half_way_ack clears it and wins over a same-cycle set.
  - Not set for number_samples==0.
- Undefined: no such ports, no logic.

## Structure
- Shared package mic_dma_pkg holds:
  - the state enum type
  - REGION_STRIDE default constant
  - the pair-index width constant (3)
- Sub-module mic_rd_fifo: synchronous FIFO of {3-bit pair, 32-bit data}, FIFO_DEPTH entries.
  - Ports: push, pop, full, empty, count.

## Test plan
- number_samples=3, NUM_MIC_PAIRS=5, base 0x1000, zero-latency slave → 15 reads to 0x1000, 0x1000+7680000, …, then 0x1004…; out stream pairs 0,1,2,3,4,0,… with matching data; end_latch=1; FIN.
- AM_WAITREQUEST held 4 cycles on the 2nd read → AM_ADDR/AM_READ stable for those 4 cycles; no duplicate or skipped address.
- out_ready=0 throughout, slave latency 3 → at most FIFO_DEPTH=8 reads accepted; AM_READ low thereafter; releasing out_ready resumes issue.
- number_samples=0 → no AM_READ, FINISHED after 2 cycles, end_latch stays 0.
- RESET asserted after 6 accepted reads with 2 outstanding; late readdatavalids follow → no out_valid; all outputs at reset values.
- With MIC_PLAYBACK_DMA_HALF_LATCH_EN and number_samples=4 → half_way_latch rises after the 2nd frame pops; half_way_ack same cycle as the set → remains 0.

Source files
------------

// File: rtl/mic_dma_pkg.sv
// Shared definitions for the microphone playback DMA: state encoding,
// default region stride, pair-index width and the region address helper.
package mic_dma_pkg;

  localparam int PAIR_W = 3;
  localparam logic [31:0] REGION_STRIDE_DEFAULT = 32'd7680000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } dma_state_e;

  // Byte address of a sample word; all arithmetic wraps modulo 2^32.
  function automatic logic [31:0] region_addr(input logic [31:0]       base,
                                              input logic [PAIR_W-1:0] pair,
                                              input logic [31:0]       sample,
                                              input logic [31:0]       stride);
    logic [31:0] pair_ext;
    pair_ext = {{(32-PAIR_W){1'b0}}, pair};
    return base + (pair_ext * stride) + {sample[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/mic_rd_fifo.sv
// Return-data FIFO for the playback DMA: holds {pair tag, data word}.
// Head outputs read zero while empty so the stream is quiet after a flush.
module mic_rd_fifo
  import mic_dma_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   push,
  input  logic [PAIR_W-1:0]      push_pair,
  input  logic [31:0]            push_data,
  input  logic                   pop,
  output logic [PAIR_W-1:0]      head_pair,
  output logic [31:0]            head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [PAIR_W+31:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  assign do_push = push && (!full || do_pop);

  assign {head_pair, head_data} = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push)
      mem[wr_ptr] <= {push_pair, push_data};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + (AW+1)'(1);
      else if (!do_push && do_pop)
        count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/mic_playback_dma.sv
// Avalon-MM read-master DMA replaying per-pair sample regions as an interleaved stream.
// Optional half-way latch ports compiled in with MIC_PLAYBACK_DMA_HALF_LATCH_EN.
module mic_playback_dma
  import mic_dma_pkg::*;
#(
  parameter int          NUM_MIC_PAIRS = 5,
  parameter logic [31:0] REGION_STRIDE = REGION_STRIDE_DEFAULT,
  parameter int          FIFO_DEPTH    = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] AM_ADDR,
  output logic [2:0]  AM_BURSTCOUNT,
  output logic [3:0]  AM_BYTEENABLE,
  output logic        AM_READ,
  input  logic        AM_WAITREQUEST,
  input  logic [31:0] AM_READDATA,
  input  logic        AM_READDATAVALID,
  input  logic        start,
  input  logic [31:0] start_address,
  input  logic [31:0] number_samples,
  input  logic        end_ack,
  output logic [31:0] out_data,
  output logic [2:0]  out_pair,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        end_latch,
  output logic        FINISHED,
  output logic        busy
`ifdef MIC_PLAYBACK_DMA_HALF_LATCH_EN
  ,
  input  logic        half_way_ack,
  output logic        half_way_latch
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NUM_MIC_PAIRS - 1);

  dma_state_e         state;
  logic [31:0]        base_addr;
  logic [31:0]        num_samples;
  logic [PAIR_W-1:0]  req_pair;
  logic [31:0]        req_sample;
  logic [PAIR_W-1:0]  ret_pair;
  logic [31:0]        frames_done;
  logic [CW-1:0]      outstanding;
  logic               final_popped;

  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic               credit_ok;
  logic               accept;
  logic               last_req;
  logic               push;
  logic               pop;
  logic               final_pop;
  logic               in_transfer;

  assign AM_BURSTCOUNT = 3'd1;
  assign AM_BYTEENABLE = 4'hF;

  assign busy        = (state == ST_SETUP) || (state == ST_ISSUE) || (state == ST_DRAIN);
  assign FINISHED    = (state == ST_FIN);
  assign in_transfer = (state == ST_ISSUE) || (state == ST_DRAIN);

  // Reads in flight plus words already buffered may never exceed the FIFO size,
  // so every returning word is guaranteed a slot.
  assign credit_ok = !fifo_full &&
                     (({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH));
  assign AM_READ   = (state == ST_ISSUE) && credit_ok;
  assign AM_ADDR   = (state == ST_ISSUE) ?
                     region_addr(base_addr, req_pair, req_sample, REGION_STRIDE) : '0;
  assign accept    = AM_READ && !AM_WAITREQUEST;
  assign last_req  = (req_pair == LAST_PAIR) && (req_sample == num_samples - 32'd1);

  assign push      = AM_READDATAVALID && in_transfer;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign final_pop = pop && (state == ST_DRAIN) && (out_pair == LAST_PAIR) &&
                     (frames_done == num_samples - 32'd1);

  mic_rd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (push),
    .push_pair (ret_pair),
    .push_data (AM_READDATA),
    .pop       (pop),
    .head_pair (out_pair),
    .head_data (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= ST_IDLE;
      base_addr    <= '0;
      num_samples  <= '0;
      req_pair     <= '0;
      req_sample   <= '0;
      ret_pair     <= '0;
      frames_done  <= '0;
      outstanding  <= '0;
      final_popped <= 1'b0;
    end else begin
      if (accept && !push)
        outstanding <= outstanding + CW'(1);
      else if (!accept && push)
        outstanding <= outstanding - CW'(1);
      // Slave returns in order, so tags simply follow issue order.
      if (push)
        ret_pair <= (ret_pair == LAST_PAIR) ? '0 : ret_pair + PAIR_W'(1);
      if (pop && in_transfer && (out_pair == LAST_PAIR))
        frames_done <= frames_done + 32'd1;
      if (final_pop)
        final_popped <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start)
            state <= ST_SETUP;
        end
        ST_SETUP: begin
          base_addr    <= start_address;
          num_samples  <= number_samples;
          req_pair     <= '0;
          req_sample   <= '0;
          ret_pair     <= '0;
          frames_done  <= '0;
          outstanding  <= '0;
          final_popped <= 1'b0;
          state        <= (number_samples == 32'd0) ? ST_FIN : ST_ISSUE;
        end
        ST_ISSUE: begin
          if (accept) begin
            if (req_pair == LAST_PAIR) begin
              req_pair   <= '0;
              req_sample <= req_sample + 32'd1;
            end else begin
              req_pair <= req_pair + PAIR_W'(1);
            end
            if (last_req)
              state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (final_popped && (outstanding == '0) && fifo_empty)
            state <= ST_FIN;
        end
        ST_FIN: begin
          if (!start)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      end_latch <= 1'b0;
    else if (end_ack)
      end_latch <= 1'b0;
    else if (final_pop)
      end_latch <= 1'b1;
  end

`ifdef MIC_PLAYBACK_DMA_HALF_LATCH_EN
  logic half_set;

  assign half_set = in_transfer && (num_samples != 32'd0) &&
                    (frames_done >= (num_samples >> 1));

  always_ff @(posedge CLK) begin
    if (RESET)
      half_way_latch <= 1'b0;
    else if (half_way_ack)
      half_way_latch <= 1'b0;
    else if (half_set)
      half_way_latch <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mic_playback_dma.sv
// Scoreboard bench for mic_playback_dma: behavioural Avalon slave plus stream monitor.
// Half-way latch checks run when MIC_PLAYBACK_DMA_HALF_LATCH_EN is defined.
module tb_mic_playback_dma;

  localparam int          NPAIRS = 5;
  localparam logic [31:0] STRIDE = 32'd7680000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] AM_ADDR;
  logic [2:0]  AM_BURSTCOUNT;
  logic [3:0]  AM_BYTEENABLE;
  logic        AM_READ;
  logic        AM_WAITREQUEST = 1'b0;
  logic [31:0] AM_READDATA = '0;
  logic        AM_READDATAVALID = 1'b0;
  logic        start = 1'b0;
  logic [31:0] start_address = '0;
  logic [31:0] number_samples = '0;
  logic        end_ack = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_pair;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        end_latch;
  logic        FINISHED;
  logic        busy;
`ifdef MIC_PLAYBACK_DMA_HALF_LATCH_EN
  logic        half_way_ack = 1'b0;
  logic        half_way_latch;
`endif

  mic_playback_dma #(
    .NUM_MIC_PAIRS (NPAIRS),
    .REGION_STRIDE (STRIDE),
    .FIFO_DEPTH    (8)
  ) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .AM_ADDR          (AM_ADDR),
    .AM_BURSTCOUNT    (AM_BURSTCOUNT),
    .AM_BYTEENABLE    (AM_BYTEENABLE),
    .AM_READ          (AM_READ),
    .AM_WAITREQUEST   (AM_WAITREQUEST),
    .AM_READDATA      (AM_READDATA),
    .AM_READDATAVALID (AM_READDATAVALID),
    .start            (start),
    .start_address    (start_address),
    .number_samples   (number_samples),
    .end_ack          (end_ack),
    .out_data         (out_data),
    .out_pair         (out_pair),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .end_latch        (end_latch),
    .FINISHED         (FINISHED),
    .busy             (busy)
`ifdef MIC_PLAYBACK_DMA_HALF_LATCH_EN
    ,
    .half_way_ack     (half_way_ack),
    .half_way_latch   (half_way_latch)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          due;
    logic [31:0] data;
  } ret_t;

  ret_t        ret_q[$];
  logic [31:0] exp_addr[$];
  logic [34:0] exp_out[$];

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          lat = 1;
  logic        ready_mode = 1'b1;
  int          acc_count = 0;
  int          frames_seen = 0;
  int          req_idx = 0;
  int          stall_index = 0;
  int          stall_left = 0;
  logic        stall_active = 1'b0;
  logic [31:0] stall_addr = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Queue the hand-derived address/data sequence, then kick off the transfer.
  task automatic applyStimulus(input logic [31:0] base, input int nsamp);
    logic [31:0] a;
    for (int s = 0; s < nsamp; s++) begin
      for (int p = 0; p < NPAIRS; p++) begin
        a = base + (32'(p) * STRIDE) + 32'(4 * s);
        exp_addr.push_back(a);
        exp_out.push_back({3'(p), ~a});
      end
    end
    start_address  = base;
    number_samples = 32'(nsamp);
    start          = 1'b1;
  endtask

  task automatic waitFinished(input int budget);
    int i;
    i = 0;
    while (!FINISHED && i < budget) begin
      waitCycles(1);
      i++;
    end
    checkOutput("finished_reached", FINISHED, 1);
  endtask

  task automatic finishTransfer();
    end_ack = 1'b1;
`ifdef MIC_PLAYBACK_DMA_HALF_LATCH_EN
    half_way_ack = 1'b1;
`endif
    waitCycles(1);
    end_ack = 1'b0;
`ifdef MIC_PLAYBACK_DMA_HALF_LATCH_EN
    half_way_ack = 1'b0;
`endif
    checkOutput("end_latch_cleared", end_latch, 0);
    start = 1'b0;
    waitCycles(2);
    checkOutput("idle_after_fin", {FINISHED, busy}, 2'b00);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_am_read"}, AM_READ, 0);
    checkOutput({tag, "_am_addr"}, AM_ADDR, 0);
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    checkOutput({tag, "_out_pair"}, out_pair, 0);
    checkOutput({tag, "_out_data"}, out_data, 0);
    checkOutput({tag, "_end_latch"}, end_latch, 0);
    checkOutput({tag, "_finished"}, FINISHED, 0);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  // Slave model and monitor: inputs change on the falling edge; the DUT
  // accepts/pops on the following rising edge.
  always @(negedge CLK) begin
    out_ready = ready_mode;

    if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
      AM_READDATAVALID = 1'b1;
      AM_READDATA      = ret_q[0].data;
      void'(ret_q.pop_front());
    end else begin
      AM_READDATAVALID = 1'b0;
      AM_READDATA      = '0;
    end

    if (stall_active) begin
      checkOutput("stall_read_held", AM_READ, 1);
      checkOutput("stall_addr_held", AM_ADDR, stall_addr);
    end

    if (!RESET && AM_READ && stall_left > 0 && req_idx == stall_index - 1) begin
      AM_WAITREQUEST = 1'b1;
      if (!stall_active) begin
        stall_active = 1'b1;
        stall_addr   = AM_ADDR;
      end
      stall_left--;
    end else begin
      AM_WAITREQUEST = 1'b0;
    end

    if (!RESET && AM_READ && !AM_WAITREQUEST) begin
      req_idx++;
      acc_count++;
      stall_active = 1'b0;
      if (exp_addr.size() == 0)
        checkOutput("unexpected_read", AM_ADDR, 32'hFFFF_FFFF);
      else
        checkOutput("read_addr", AM_ADDR, exp_addr.pop_front());
      ret_q.push_back('{due: cyc + lat, data: ~AM_ADDR});
    end

    if (!RESET && out_valid && out_ready) begin
      if (exp_out.size() == 0)
        checkOutput("unexpected_out", {out_pair, out_data}, 35'h7_FFFF_FFFF);
      else
        checkOutput("out_word", {out_pair, out_data}, exp_out.pop_front());
      if (out_pair == 3'(NPAIRS - 1))
        frames_seen++;
    end

    cyc++;
  end

  initial begin
    int acc0;
    int i;
    int bad;

    waitCycles(3);
    checkResetValues("reset");
    checkOutput("burstcount", AM_BURSTCOUNT, 3'd1);
    checkOutput("byteenable", AM_BYTEENABLE, 4'hF);
    RESET = 1'b0;
    waitCycles(1);

    // Basic 3-sample transfer, zero-latency slave.
    $display("[TB] basic transfer");
    lat = 1;
    ready_mode = 1'b1;
    applyStimulus(32'h0000_1000, 3);
    checkOutput("second_addr_literal", exp_addr[1], 32'h0075_4000);
    waitCycles(1);
    checkOutput("setup_no_read", {busy, AM_READ}, 2'b10);
    waitCycles(1);
    checkOutput("first_read_cycle2", AM_READ, 1);
    checkOutput("first_addr", AM_ADDR, 32'h0000_1000);
    waitFinished(200);
    checkOutput("basic_end_latch", end_latch, 1);
    checkOutput("basic_addr_left", exp_addr.size(), 0);
    checkOutput("basic_out_left", exp_out.size(), 0);
    acc0 = acc_count;
    waitCycles(3);
    checkOutput("fin_holds_with_start", FINISHED, 1);
    checkOutput("fin_no_restart", acc_count - acc0, 0);
    finishTransfer();

    // Waitrequest held for 4 cycles on the second read.
    $display("[TB] waitrequest stall");
    req_idx = 0;
    stall_index = 2;
    stall_left = 4;
    applyStimulus(32'h0000_2000, 1);
    waitFinished(200);
    checkOutput("stall_consumed", stall_left, 0);
    checkOutput("stall_addr_left", exp_addr.size(), 0);
    checkOutput("stall_out_left", exp_out.size(), 0);
    finishTransfer();

    // Back-pressure: credit limits reads to the FIFO depth.
    $display("[TB] credit limit");
    lat = 3;
    ready_mode = 1'b0;
    acc0 = acc_count;
    applyStimulus(32'h0000_0000, 3);
    waitCycles(30);
    checkOutput("credit_reads", acc_count - acc0, 8);
    checkOutput("credit_read_low", AM_READ, 0);
    checkOutput("credit_out_valid", out_valid, 1);
    checkOutput("credit_head_hold", {out_pair, out_data}, {3'd0, ~32'h0});
    ready_mode = 1'b1;
    waitFinished(300);
    checkOutput("credit_total_reads", acc_count - acc0, 15);
    checkOutput("credit_out_left", exp_out.size(), 0);
    checkOutput("credit_end_latch", end_latch, 1);
    finishTransfer();

    // Zero-length transfer.
    $display("[TB] zero samples");
    lat = 1;
    acc0 = acc_count;
    applyStimulus(32'h0000_3000, 0);
    waitCycles(1);
    checkOutput("zero_fin_cycle1", FINISHED, 0);
    waitCycles(1);
    checkOutput("zero_fin_cycle2", FINISHED, 1);
    checkOutput("zero_no_reads", acc_count - acc0, 0);
    checkOutput("zero_end_latch", end_latch, 0);
    start = 1'b0;
    waitCycles(2);

    // Reset with reads still in flight.
    $display("[TB] reset mid-transfer");
    lat = 2;
    acc0 = acc_count;
    applyStimulus(32'h0000_4000, 3);
    i = 0;
    while (acc_count - acc0 < 6 && i < 60) begin
      waitCycles(1);
      i++;
    end
    checkOutput("six_reads_before_reset", acc_count - acc0, 6);
    RESET = 1'b1;
    start = 1'b0;
    exp_addr.delete();
    exp_out.delete();
    waitCycles(1);
    RESET = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      waitCycles(1);
      if (out_valid !== 1'b0 || AM_READ !== 1'b0)
        bad++;
    end
    checkOutput("no_output_after_reset", bad, 0);
    checkOutput("late_returns_drained", ret_q.size(), 0);
    checkResetValues("midreset");

`ifdef MIC_PLAYBACK_DMA_HALF_LATCH_EN
    $display("[TB] half-way latch");
    lat = 1;
    acc0 = frames_seen;
    applyStimulus(32'h0000_5000, 4);
    i = 0;
    while (frames_seen - acc0 < 1 && i < 100) begin
      waitCycles(1);
      i++;
    end
    checkOutput("half_low_after_frame1", half_way_latch, 0);
    i = 0;
    while (frames_seen - acc0 < 2 && i < 100) begin
      waitCycles(1);
      i++;
    end
    waitCycles(2);
    checkOutput("half_set_after_frame2", half_way_latch, 1);
    waitFinished(200);
    finishTransfer();
    checkOutput("half_cleared_by_ack", half_way_latch, 0);

    half_way_ack = 1'b1;
    applyStimulus(32'h0000_6000, 4);
    waitFinished(200);
    checkOutput("half_ack_wins", half_way_latch, 0);
    checkOutput("half_out_left", exp_out.size(), 0);
    finishTransfer();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
